// File: rtl/mult_seq_if.sv
// ============================================================================
//  Module      : mult_seq_if
//  Description : Handshake/operand/result bundle between the DLX decoder and
//                the iterative multiply sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mult_seq_if;
    logic        start;
    logic        is_signed;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        busy;
    logic        stall;
    logic        done;
    logic [63:0] product;

    // Decoder side: issues requests, observes status and result.
    modport master (
        output start, is_signed, op_a, op_b, flush,
        input  busy, stall, done, product
    );

    // Sequencer side.
    modport slave (
        input  start, is_signed, op_a, op_b, flush,
        output busy, stall, done, product
    );
endinterface

`default_nettype wire

// File: rtl/mult_seq.sv
// ============================================================================
//  Module      : mult_seq
//  Description : Iterative 32x32 radix-2 shift-add multiplier for the DLX
//                mult/multu instructions. Holds stall while iterating and
//                returns a registered 64-bit product with a one-cycle done.
//                Optional macro MULT_EARLY_TERM_EN ends the loop as soon as
//                the remaining multiplier is zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_seq #(
    parameter int ITER_W = 6
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    mult_seq_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Counter value during the 32nd (final) iteration.
    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(31);

    state_t             state_q, state_d;
    logic [63:0]        mcand_q, mcand_d;
    logic [31:0]        mplier_q, mplier_d;
    logic [63:0]        acc_q, acc_d;
    logic [ITER_W-1:0]  cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic [63:0]        product_q, product_d;

    // Operand magnitudes; 0x80000000 negates to itself, which read as
    // unsigned is exactly the required magnitude.
    logic [31:0] mag_a_w, mag_b_w;
    assign mag_a_w = (bus.is_signed && bus.op_a[31]) ? (~bus.op_a + 32'd1) : bus.op_a;
    assign mag_b_w = (bus.is_signed && bus.op_b[31]) ? (~bus.op_b + 32'd1) : bus.op_b;

    // State and datapath registers; reset discards any partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            product_q <= product_d;
        end
    end

    // Next-state and datapath update: accept, iterate, sign-fix, report.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        product_d = product_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                // flush outranks start: nothing is latched on a flushed request.
                if (!bus.flush && bus.start) begin
                    mcand_d  = {32'd0, mag_a_w};
                    mplier_d = mag_b_w;
                    neg_d    = bus.is_signed & (bus.op_a[31] ^ bus.op_b[31]);
                    acc_d    = '0;
                    cnt_d    = '0;
`ifdef MULT_EARLY_TERM_EN
                    // A zero multiplier needs no iterations at all.
                    state_d  = (mag_b_w == 32'd0) ? FIX : RUN;
`else
                    state_d  = RUN;
`endif
                end
            end

            RUN: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + ITER_W'(1);
                    if (cnt_q == LAST_ITER) begin
                        state_d = FIX;
                    end
`ifdef MULT_EARLY_TERM_EN
                    // Remaining multiplier becomes zero after this shift, so
                    // further iterations cannot change the accumulator.
                    if (mplier_q[31:1] == 31'd0) begin
                        state_d = FIX;
                    end
`endif
                end
            end

            FIX: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    product_d = neg_q ? (~acc_q + 64'd1) : acc_q;
                    state_d   = DONE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status outputs decode from state only; no input-to-output paths.
    assign bus.busy    = (state_q == RUN) || (state_q == FIX);
    assign bus.stall   = bus.busy;
    assign bus.done    = (state_q == DONE);
    assign bus.product = product_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_seq.sv
// ============================================================================
//  Module      : tb_mult_seq
//  Description : Scoreboard bench for mult_seq. The driver pushes expected
//                product and latency on acceptance; a monitor pops on done.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_seq;

    logic clk;
    logic rst_n;
    int   cyc;
    int   vectors;
    int   miscompares;
    int   done_cnt;
    int   pushed_cnt;

    mult_seq_if bus();

    mult_seq #(.ITER_W(6)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [63:0] prod;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected acceptance-to-done latency in cycles.
    function automatic int exp_lat(input logic s, input logic [31:0] b);
`ifdef MULT_EARLY_TERM_EN
        logic [31:0] m;
        int k;
        m = (s && b[31]) ? (~b + 32'd1) : b;
        k = 0;
        for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
        return 2 + k;
`else
        return 34;
`endif
    endfunction

    // Monitor: every done must match the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            done_cnt++;
            if (bus.busy) begin
                miscompares++;
                $display("FAIL done_busy_overlap busy=%0b required 0", bus.busy);
            end
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done product=%h required no done", bus.product);
            end else begin
                exp_t e;
                e = sb.pop_front();
                vectors++;
                if (bus.product !== e.prod) begin
                    miscompares++;
                    $display("FAIL product got=%h required=%h", bus.product, e.prod);
                end
                vectors++;
                if ((cyc - e.acc_cyc) != (e.lat - 1)) begin
                    miscompares++;
                    $display("FAIL latency got=%0d required=%0d", cyc - e.acc_cyc + 1, e.lat);
                end
                vectors++;
                if (bus.stall !== 1'b0) begin
                    miscompares++;
                    $display("FAIL stall_in_done got=%0b required 0", bus.stall);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    // Drive one request; caller is positioned at a negedge.
    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp_p, input bit push);
        bus.start     = 1'b1;
        bus.is_signed = s;
        bus.op_a      = a;
        bus.op_b      = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (push) begin
            exp_t e;
            e.prod    = exp_p;
            e.lat     = exp_lat(s, b);
            e.acc_cyc = cyc;
            sb.push_back(e);
            pushed_cnt++;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout pending=%0d required 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int n;
        cyc           = 0;
        vectors       = 0;
        miscompares   = 0;
        done_cnt      = 0;
        pushed_cnt    = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.flush     = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_busy",    {63'd0, bus.busy},  64'd0);
        check("reset_stall",   {63'd0, bus.stall}, 64'd0);
        check("reset_done",    {63'd0, bus.done},  64'd0);
        check("reset_product", bus.product,        64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Unsigned max, with stall visible in the first RUN cycle.
        issue(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 1'b1);
        @(negedge clk);
        check("stall_running", {63'd0, bus.stall}, 64'd1);
        drain();

        // Signed cases.
        issue(1'b1, 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFFFFFFFFEB, 1'b1);
        drain();
        issue(1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000, 1'b1);
        drain();

        // Back-to-back: second start lands in the DONE cycle.
        issue(1'b0, 32'd7, 32'd9, 64'h3F, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < 100);
        issue(1'b0, 32'd5, 32'd6, 64'h1E, 1'b1);
        drain();

        // Start mid-RUN must be ignored.
        issue(1'b0, 32'd4, 32'h40000000, 64'h0000000100000000, 1'b1);
        repeat (5) @(negedge clk);
        issue(1'b0, 32'd9, 32'd9, 64'd0, 1'b0);
        drain();
        repeat (40) @(negedge clk);
        check("done_count", 64'(done_cnt), 64'(pushed_cnt));

        // Flush at iteration 10: no done, product retained.
        issue(1'b0, 32'd3, 32'hFFFFFFFF, 64'd0, 1'b0);
        repeat (9) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        check("flush_busy",    {63'd0, bus.busy}, 64'd0);
        check("flush_done",    {63'd0, bus.done}, 64'd0);
        check("flush_product", bus.product,       64'h0000000100000000);
        repeat (40) @(negedge clk);

        // Asynchronous reset at iteration 20.
        @(negedge clk);
        issue(1'b1, 32'h12345678, 32'hFFFFFFFF, 64'd0, 1'b0);
        repeat (20) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy",    {63'd0, bus.busy},  64'd0);
        check("rst_stall",   {63'd0, bus.stall}, 64'd0);
        check("rst_done",    {63'd0, bus.done},  64'd0);
        check("rst_product", bus.product,        64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(1'b0, 32'd2, 32'd3, 64'h6, 1'b1);
        drain();

        // Early-termination boundary vectors (fixed 34 cycles otherwise).
        issue(1'b0, 32'd5, 32'd3, 64'hF, 1'b1);
        drain();
        issue(1'b0, 32'hDEADBEEF, 32'd0, 64'h0, 1'b1);
        drain();
        issue(1'b0, 32'd1, 32'h80000000, 64'h0000000080000000, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
